pattern_shift_gen: RTL and testbench

//  Parametrised LED/IO pattern generator: a WIDTH-bit shift register with selectable
//  NOR/toggle/rotate/LFSR feedback, advanced by an internal prescaler tick. The output
//  can be bit-mirrored, either from a pin or from an auto-toggle on all-zero entry.

---
 rtl/pattern_shift_gen.sv | 101 ++++++++++
 tb/tb_pattern_shift_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_shift_gen.sv
// WIDTH-bit pattern shift register with selectable feedback, prescaled stepping and output mirroring.
// Optional LFSR feedback (mode 5) is built only when PATTERN_SHIFT_GEN_LFSR_EN is defined.
module pattern_shift_gen #(
  parameter int               WIDTH = 8,
  parameter int               DIV_W = 11,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mir_sel,
  input  logic             mir_in,
  output logic [WIDTH-1:0] pattern_o,
  output logic             tick_o,
  output logic             mirror_o
);

  localparam logic [2:0] M_TOGGLE = 3'd1;
  localparam logic [2:0] M_NOR2   = 3'd2;
  localparam logic [2:0] M_NOR4   = 3'd3;
  localparam logic [2:0] M_NORALL = 3'd4;
  localparam logic [2:0] M_LFSR   = 3'd5;
  localparam logic [2:0] M_ROTL   = 3'd6;
  localparam logic [2:0] M_ROTR   = 3'd7;

  if (WIDTH < 4 || $bits(TAPS) != WIDTH) begin : g_bad_width
    $error("pattern_shift_gen: WIDTH must be >= 4 and TAPS must be WIDTH bits");
  end

  logic [WIDTH-1:0] sr_q, sr_d, sr_step;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick;
  logic             zero_q, zero_d;
  logic             mir_tgl_q, mir_tgl_d;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

`ifdef PATTERN_SHIFT_GEN_LFSR_EN
  logic lfsr_fb;
  // All-zero state would lock a pure XOR feedback, so force a 1 in.
  assign lfsr_fb = (sr_q == '0) ? 1'b1 : ^(sr_q & TAPS);
`endif

  always_comb begin
    sr_step = sr_q;
    case (mode)
      M_TOGGLE: sr_step = {sr_q[WIDTH-2:0], ~sr_q[0]};
      M_NOR2:   sr_step = {sr_q[WIDTH-2:0], ~|sr_q[1:0]};
      M_NOR4:   sr_step = {sr_q[WIDTH-2:0], ~|sr_q[3:0]};
      M_NORALL: sr_step = {sr_q[WIDTH-2:0], ~|sr_q};
`ifdef PATTERN_SHIFT_GEN_LFSR_EN
      M_LFSR:   sr_step = {sr_q[WIDTH-2:0], lfsr_fb};
`endif
      M_ROTL:   sr_step = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
      M_ROTR:   sr_step = {sr_q[0], sr_q[WIDTH-1:1]};
      default:  sr_step = sr_q;
    endcase
  end

  // >= rather than == so a div_val lowered below the running count still wraps.
  always_comb begin
    tick = div_en ? (cnt_q >= div_val) : 1'b1;
    if (load || !div_en || tick) cnt_d = '0;
    else                         cnt_d = cnt_q + DIV_W'(1);
    if (load)      sr_d = load_val;
    else if (tick) sr_d = sr_step;
    else           sr_d = sr_q;
    zero_d    = (sr_q == '0);
    mir_tgl_d = mir_tgl_q ^ ((sr_q == '0) && !zero_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q      <= SEED;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      zero_q    <= (SEED == '0);
      mir_tgl_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick;
      zero_q    <= zero_d;
      mir_tgl_q <= mir_tgl_d;
    end
  end

  assign mirror_o  = mir_sel ? mir_in : mir_tgl_q;
  assign pattern_o = mirror_o ? bitrev(sr_q) : sr_q;
  assign tick_o    = tick_q;

endmodule

// File: tb/tb_pattern_shift_gen.sv
// Directed and randomized bench for pattern_shift_gen (WIDTH=8, SEED=0) with a behavioural model.
module tb_pattern_shift_gen;
  localparam int W    = 8;
  localparam int DW   = 11;
  localparam int MASK = 255;
  localparam int TAPS = 'hB8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    mode;
  logic          div_en;
  logic [DW-1:0] div_val;
  logic          load;
  logic [W-1:0]  load_val;
  logic          mir_sel;
  logic          mir_in;
  logic [W-1:0]  pattern_o;
  logic          tick_o;
  logic          mirror_o;

  int checks   = 0;
  int failures = 0;
  int m_sr = 0, m_cnt = 0, m_tgl = 0, m_zero = 1, m_tick = 0;

  always #5 clk = ~clk;

  pattern_shift_gen dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .div_en(div_en), .div_val(div_val),
    .load(load), .load_val(load_val), .mir_sel(mir_sel), .mir_in(mir_in),
    .pattern_o(pattern_o), .tick_o(tick_o), .mirror_o(mirror_o)
  );

  function automatic int rev(int v);
    int r = 0;
    for (int i = 0; i < W; i++) if (((v >> i) & 1) == 1) r = r | (1 << (W - 1 - i));
    return r;
  endfunction

  // Next pattern value for one step in the given mode, from the mode table.
  function automatic int nxt(int s, int md);
    int fb;
    case (md)
      1: fb = (s % 2 == 0) ? 1 : 0;
      2: fb = (s % 4 == 0) ? 1 : 0;
      3: fb = (s % 16 == 0) ? 1 : 0;
      4: fb = (s == 0) ? 1 : 0;
`ifdef PATTERN_SHIFT_GEN_LFSR_EN
      5: fb = (s == 0) ? 1 : ($countones(s & TAPS) % 2);
`endif
      6: return ((s * 2) + (s / 128)) % 256;
      7: return (s / 2) + ((s % 2) * 128);
      default: return s;
    endcase
    return ((s * 2) + fb) & MASK;
  endfunction

  function automatic int exp_mirror();
    return mir_sel ? int'(mir_in) : m_tgl;
  endfunction

  function automatic int exp_pattern();
    return (exp_mirror() != 0) ? rev(m_sr) : m_sr;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(string tag);
    chk({tag, "_pattern"}, 32'(pattern_o), exp_pattern());
    chk({tag, "_tick"}, 32'(tick_o), m_tick);
    chk({tag, "_mirror"}, 32'(mirror_o), exp_mirror());
  endtask

  // One clock: advance the model with the present inputs, then compare after the edge.
  task automatic cyc();
    int tk, n_sr, n_cnt, n_tgl, n_zero;
    if (!rst_n) begin
      n_sr = 0; n_cnt = 0; n_tgl = 0; n_zero = 1; tk = 0;
    end else begin
      tk     = div_en ? ((m_cnt >= int'(div_val)) ? 1 : 0) : 1;
      n_cnt  = (load || !div_en || tk == 1) ? 0 : m_cnt + 1;
      n_zero = (m_sr == 0) ? 1 : 0;
      n_tgl  = (m_sr == 0 && m_zero == 0) ? 1 - m_tgl : m_tgl;
      n_sr   = load ? int'(load_val) : (tk == 1) ? nxt(m_sr, int'(mode)) : m_sr;
    end
    @(posedge clk);
    #1;
    m_sr = n_sr; m_cnt = n_cnt; m_tgl = n_tgl; m_zero = n_zero; m_tick = tk;
    chk_outputs("cyc");
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0; div_en = 1'b0; mir_sel = 1'b0; mir_in = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  int t1[10] = '{'h01, 'h02, 'h05, 'h0A, 'h15, 'h2A, 'h55, 'hAA, 'h55, 'hAA};
  int t2[11] = '{'h01, 'h02, 'h04, 'h09, 'h12, 'h24, 'h49, 'h92, 'h24, 'h49, 'h92};
  int t3[19] = '{'h01, 'h02, 'h04, 'h08, 'h10, 'h20, 'h40, 'h80, 'h00, 'h80,
                 'h40, 'h20, 'h10, 'h08, 'h04, 'h02, 'h01, 'h00, 'h01};

  initial begin
    rst_n = 1'b0; mode = 3'd0; div_en = 1'b0; div_val = '0; load = 1'b0;
    load_val = '0; mir_sel = 1'b0; mir_in = 1'b0;
    cyc();
    cyc();
    chk("rst_pattern", 32'(pattern_o), 0);
    chk("rst_tick", 32'(tick_o), 0);
    chk("rst_mirror", 32'(mirror_o), 0);

    // Toggle feedback, one step per cycle
    rst_n = 1'b1; mode = 3'd1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("t1_step%0d", i), 32'(pattern_o), t1[i]);
    end

    // NOR2 feedback
    do_reset(); mode = 3'd2;
    for (int i = 0; i < 11; i++) begin
      cyc();
      chk($sformatf("t2_step%0d", i), 32'(pattern_o), t2[i]);
    end

    // NORALL with auto-mirror flipping on each all-zero entry
    do_reset(); mode = 3'd4;
    for (int i = 0; i < 19; i++) begin
      cyc();
      chk($sformatf("t3_step%0d", i), 32'(pattern_o), t3[i]);
      if (i == 8)  chk("t3_mirror_at_zero", 32'(mirror_o), 0);
      if (i == 9)  chk("t3_mirror_after_zero", 32'(mirror_o), 1);
      if (i == 18) chk("t3_mirror_back", 32'(mirror_o), 0);
    end

    // Prescaled rotate-left, then load colliding with a tick
    do_reset(); div_en = 1'b1; div_val = DW'(3); mode = 3'd6; load = 1'b1; load_val = 8'h81;
    cyc();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t4_wait_sr", 32'(pattern_o), 'h81);
      chk("t4_wait_tick", 32'(tick_o), 0);
    end
    cyc();
    chk("t4_step1_sr", 32'(pattern_o), 'h03);
    chk("t4_step1_tick", 32'(tick_o), 1);
    repeat (4) cyc();
    chk("t4_step2_sr", 32'(pattern_o), 'h06);
    chk("t4_step2_tick", 32'(tick_o), 1);
    repeat (3) cyc();
    load = 1'b1; load_val = 8'h5A;
    cyc();
    chk("t4_load_beats_tick", 32'(pattern_o), 'h5A);
    chk("t4_load_tick_o", 32'(tick_o), 1);
    load = 1'b0;
    repeat (3) cyc();
    chk("t4_restart_hold", 32'(pattern_o), 'h5A);
    cyc();
    chk("t4_restart_step", 32'(pattern_o), 'hB4);

    // LFSR mode from all-zero
    do_reset(); mode = 3'd5;
`ifdef PATTERN_SHIFT_GEN_LFSR_EN
    begin
      bit [255:0] seen;
      int distinct;
      seen = '0; distinct = 0;
      cyc();
      chk("t5_first", 32'(pattern_o), 1);
      for (int i = 0; i < 255; i++) begin
        if (!seen[int'(pattern_o)]) distinct++;
        seen[int'(pattern_o)] = 1'b1;
        cyc();
      end
      chk("t5_distinct", 32'(distinct), 255);
      chk("t5_wrap", 32'(pattern_o), 1);
    end
`else
    repeat (8) cyc();
    chk("t5_hold", 32'(pattern_o), 0);
`endif

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0)  mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) div_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) div_val = DW'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0)  mir_sel = 1'($urandom_range(0, 1));
      mir_in   = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 15) == 0);
      load_val = ($urandom_range(0, 3) == 0) ? 8'h00 : W'($urandom);
      rst_n    = ($urandom_range(0, 199) != 0);
      cyc();
    end

    // Direct mirror pin, then reset mid-run
    rst_n = 1'b1; load = 1'b1; load_val = 8'h35; div_en = 1'b1; div_val = DW'(2);
    mir_sel = 1'b0; mir_in = 1'b0;
    cyc();
    load = 1'b0;
    mir_sel = 1'b1; mir_in = 1'b0;
    #1;
    chk("t6_pin_low", 32'(pattern_o), 32'(m_sr));
    mir_in = 1'b1;
    #1;
    chk("t6_pin_high", 32'(pattern_o), 32'(rev(m_sr)));
    chk("t6_pin_mirror", 32'(mirror_o), 1);
    cyc();
    rst_n = 1'b0; load = 1'b1; load_val = 8'hFF;
    cyc();
    chk("t6_rst_pattern", 32'(pattern_o), 0);
    chk("t6_rst_tick", 32'(tick_o), 0);
    rst_n = 1'b1; load = 1'b0; mir_sel = 1'b0;
    #1;
    chk("t6_rst_mirror", 32'(mirror_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
